// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generator for the DLX EX-stage operand muxes.
// Optional saturating statistics counters are built when FWD_STATS_EN is defined.
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_wr_en,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  stall
`ifdef FWD_STATS_EN
    ,
    output logic [CNT_W-1:0]      stat_fwd_cnt,
    output logic [CNT_W-1:0]      stat_stl_cnt
`endif
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic                  wr;
        logic                  load;
    } stage_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    // The WB occupant writes the register file in the same cycle a consumer
    // reads it, so no forwarding decision ever consults it; EX and MEM suffice.
    stage_t     ex_q, mem_q;
    stage_t     id_entry;
    logic       kill_id;
    logic [1:0] sel_a_nxt, sel_b_nxt;

    // A write to r0 is stored as a bubble so it can never match a reader.
    always_comb begin
        id_entry      = '0;
        id_entry.dst  = id_dst;
        id_entry.wr   = id_wr_en && (id_dst != '0);
        id_entry.load = id_is_load && id_entry.wr;
    end

    assign stall   = id_valid && ex_q.wr && ex_q.load &&
                     ((ex_q.dst == id_rs) || (ex_q.dst == id_rt));
    assign kill_id = stall || flush || !id_valid;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_a_nxt = SEL_RF;
        sel_b_nxt = SEL_RF;
        if (!kill_id) begin
            if (ex_q.wr && ex_q.dst == id_rs)        sel_a_nxt = SEL_MEM;
            else if (mem_q.wr && mem_q.dst == id_rs) sel_a_nxt = SEL_WB;
            if (ex_q.wr && ex_q.dst == id_rt)        sel_b_nxt = SEL_MEM;
            else if (mem_q.wr && mem_q.dst == id_rt) sel_b_nxt = SEL_WB;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q      <= '0;
            mem_q     <= '0;
            fwd_sel_a <= SEL_RF;
            fwd_sel_b <= SEL_RF;
        end else begin
            mem_q     <= flush   ? '0 : ex_q;
            ex_q      <= kill_id ? '0 : id_entry;
            fwd_sel_a <= sel_a_nxt;
            fwd_sel_b <= sel_b_nxt;
        end
    end

`ifdef FWD_STATS_EN
    logic fwd_event;
    assign fwd_event = (sel_a_nxt != SEL_RF) || (sel_b_nxt != SEL_RF);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fwd_cnt <= '0;
            stat_stl_cnt <= '0;
        end else begin
            if (fwd_event && stat_fwd_cnt != '1) stat_fwd_cnt <= stat_fwd_cnt + CNT_W'(1);
            if (stall && stat_stl_cnt != '1)     stat_stl_cnt <= stat_stl_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized and directed bench for fwd_hazard_unit against an in-flight instruction history model.
// Counter checks are compiled in when FWD_STATS_EN is defined.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       id_wr_en, id_is_load, flush;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic       stall;
`ifdef FWD_STATS_EN
    logic [15:0] stat_fwd_cnt, stat_stl_cnt;
`endif

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall)
`ifdef FWD_STATS_EN
        , .stat_fwd_cnt(stat_fwd_cnt), .stat_stl_cnt(stat_stl_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: history of instructions issued into EX, youngest first.
    typedef struct {
        int dst;
        bit writes;
        bit is_load;
    } instr_t;

    instr_t hist[$];
    int     m_fwd_cnt = 0;
    int     m_stl_cnt = 0;

    // Distance of the youngest live writer of r: 0 -> now in EX, 1 -> now in MEM.
    function automatic int producer_age(int r);
        for (int i = 0; i < 2 && i < hist.size(); i++)
            if (hist[i].writes && hist[i].dst != 0 && hist[i].dst == r) return i;
        return -1;
    endfunction

    function automatic logic [1:0] age_to_sel(int age);
        if (age == 0) return 2'b10;
        if (age == 1) return 2'b01;
        return 2'b00;
    endfunction

    task automatic step(input bit v, input int rs, input int rt, input int dst,
                        input bit wr, input bit ld, input bit fl, input bit rst);
        bit         exp_stall;
        logic [1:0] exp_a, exp_b;
        instr_t     issued;
        @(negedge clk);
        reset = rst; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_dst = 5'(dst);
        id_wr_en = wr; id_is_load = ld; flush = fl;
        #1;
        exp_stall = v && hist.size() > 0 && hist[0].writes && hist[0].is_load && hist[0].dst != 0
                    && (hist[0].dst == rs || hist[0].dst == rt);
        check("stall", 16'(stall), 16'(exp_stall));
        exp_a = 2'b00;
        exp_b = 2'b00;
        if (v && !exp_stall && !fl) begin
            exp_a = age_to_sel(producer_age(rs));
            exp_b = age_to_sel(producer_age(rt));
        end
        @(posedge clk);
        #1;
        if (rst) begin
            hist.delete();
            exp_a = 2'b00;
            exp_b = 2'b00;
            m_fwd_cnt = 0;
            m_stl_cnt = 0;
        end else begin
            issued.dst     = dst;
            issued.writes  = v && wr && !exp_stall && !fl;
            issued.is_load = ld;
            if (fl && hist.size() > 0) hist[0].writes = 1'b0;
            hist.push_front(issued);
            if (hist.size() > 3) void'(hist.pop_back());
            if (exp_a != 0 || exp_b != 0) m_fwd_cnt++;
            if (exp_stall) m_stl_cnt++;
        end
        check("sel_a", 16'(fwd_sel_a), 16'(exp_a));
        check("sel_b", 16'(fwd_sel_b), 16'(exp_b));
`ifdef FWD_STATS_EN
        check("fwd_cnt", stat_fwd_cnt, 16'(m_fwd_cnt));
        check("stl_cnt", stat_stl_cnt, 16'(m_stl_cnt));
`endif
    endtask

    initial begin
        reset = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_dst = 0;
        id_wr_en = 0; id_is_load = 0; flush = 0;

        // reset state
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_sel_a", 16'(fwd_sel_a), 16'h0);
        check("rst_stall", 16'(stall), 16'h0);

        // add r3 ; add r4,r3,r1
        step(1, 1, 2, 3, 1, 0, 0, 1);
        step(1, 1, 2, 3, 1, 0, 0, 0);
        step(1, 3, 1, 4, 1, 0, 0, 0);
        check("b2b_sel_a", 16'(fwd_sel_a), 16'h2);
        check("b2b_sel_b", 16'(fwd_sel_b), 16'h0);

        // add r3 ; nop ; sub r5,r1,r3
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 2, 3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 5, 1, 0, 0, 0);
        check("gap_sel_b", 16'(fwd_sel_b), 16'h1);

        // lw r2 ; add r6,r2,r2 (held one cycle by the stall)
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 2, 1, 1, 0, 0);
        step(1, 2, 2, 6, 1, 0, 0, 0);
        check("lu_sel_stalled", 16'(fwd_sel_a), 16'h0);
        step(1, 2, 2, 6, 1, 0, 0, 0);
        check("lu_sel_a", 16'(fwd_sel_a), 16'h1);
        check("lu_sel_b", 16'(fwd_sel_b), 16'h1);
        check("lu_no_restall", 16'(stall), 16'h0);
`ifdef FWD_STATS_EN
        check("lu_stl_cnt", stat_stl_cnt, 16'h1);
`endif

        // add r7 ; add r7 ; or r8,r7,r0
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 2, 7, 1, 0, 0, 0);
        step(1, 3, 4, 7, 1, 0, 0, 0);
        step(1, 7, 0, 8, 1, 0, 0, 0);
        check("young_sel_a", 16'(fwd_sel_a), 16'h2);
        check("r0_sel_b", 16'(fwd_sel_b), 16'h0);

        // writes (including a load) to r0, then readers of r0
        step(1, 1, 1, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 9, 1, 0, 0, 0);
        check("r0_sel_a", 16'(fwd_sel_a), 16'h0);

        // lw r2 flushed out of EX, then add r2 ; then reset mid-sequence
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 2, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 2, 2, 6, 1, 0, 0, 0);
        check("flush_sel_a", 16'(fwd_sel_a), 16'h0);
        step(1, 6, 1, 4, 1, 0, 0, 0);
        step(1, 4, 6, 5, 1, 0, 0, 1);
        check("midrst_sel_a", 16'(fwd_sel_a), 16'h0);
        check("midrst_sel_b", 16'(fwd_sel_b), 16'h0);

        // randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 2000; n++) begin
            step(($urandom % 8) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), ($urandom % 4) != 0, ($urandom % 3) == 0,
                 ($urandom % 12) == 0, ($urandom % 80) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
